mem_stage: RTL and testbench
============================

# mem_stage

Memory-stage access controller for the 16-bit pipeline. It sits between the EX/MEM register and the MEM/WB register. It turns a load or store from the instruction in MEM into a level-held request to the multi-cycle data memory, and raises Stall to hold the pipeline until the access completes. It also registers load data as MEM_memOut for the MEM/WB register and flags misaligned or timed-out accesses.

## Interface
Parameters:
- TIMEOUT, 64: maximum ACCESS cycles without dm_done before the access is abandoned (8-bit counter; legal range 1..255).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- memRead  in  1  instruction in MEM is a load.
- memWrite  in  1  instruction in MEM is a store.
- addr  in  16  byte address (ALU result).
- wrData  in  16  store data.
- dm_rdData  in  16  data-memory read data; valid when dm_done=1.
- dm_done  in  1  data memory completes the current request this cycle.
- dm_addr  out  16  latched request address.
- dm_wrData  out  16  latched store data.
- dm_rd  out  1  read request, held high for the whole of ACCESS.
- dm_wr  out  1  write request, held high for the whole of ACCESS.
- MEM_memOut  out  16  registered load result, to the MEM/WB register.
- Stall  out  1  holds the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- err  out  1  sticky error flag: misaligned access, read+write conflict, or timeout.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- acc = memRead | memWrite.
- bad = acc & (addr[0] | (memRead & memWrite)).
- IDLE:
  - acc & ~bad: latch addr, wrData and op into dm_addr, dm_wrData and the op flag; go to ACCESS.
  - bad: set err; no request; stay in IDLE; the instruction advances with no stall.
  - dm_done is ignored in IDLE.
- ACCESS:
  - dm_rd = latched read op; dm_wr = latched write op.
  - The timeout counter increments each cycle.
  - On dm_done: for reads, MEM_memOut <= dm_rdData; go to DONE.
  - If the counter reaches TIMEOUT-1 without dm_done: set err, MEM_memOut <= 16'hFFFF, go to DONE.
- DONE:
  - No request is issued.
  - Inputs are ignored, so the instruction still presented is not reissued.
  - Unconditionally go to IDLE.
- Stall = (IDLE & acc & ~bad) | ACCESS. Stall is low in DONE, which lets the instruction advance.
- Stores and non-memory instructions leave MEM_memOut holding its last value.
- err is cleared only by reset.
- The timeout counter clears on entry to ACCESS.

## Timing
- Reset values:
  - state = IDLE.
  - MEM_memOut, dm_addr, dm_wrData = 16'h0000.
  - dm_rd, dm_wr, err = 0.
  - counter = 0.
- Stall is combinational from state and inputs. dm_rd and dm_wr decode directly from the state register, with no input dependence.
- Access sequence, with dm_done in the first ACCESS cycle:
  - cycle 0: IDLE, Stall=1.
  - cycle 1: ACCESS, dm_rd or dm_wr = 1, Stall=1.
  - cycle 2: DONE, MEM_memOut valid, Stall=0.
  - MEM/WB captures at the end of cycle 2.
- Minimum cost is 3 cycles per access, including 2 stall cycles. Each extra memory wait cycle adds one cycle.
- Back-to-back accesses: the next instruction reaches MEM in the cycle after DONE and is handled from IDLE. Accesses never overlap.
- Reset asserted mid-ACCESS: dm_rd and dm_wr drop immediately; a dm_done arriving after reset release is ignored (IDLE).
- dm_done coinciding with timeout expiry: dm_done wins, and err is not set.

## Test plan
- Aligned load at addr=16'h0010, dm_done on the 2nd ACCESS cycle with dm_rdData=16'hBEEF:
  - Stall high for 3 cycles.
  - dm_rd high for 2 cycles with dm_addr=16'h0010.
  - MEM_memOut=16'hBEEF in DONE; err=0.
- Store at addr=16'h0020 with wrData=16'h1234, dm_done immediate:
  - dm_wr high 1 cycle with dm_wrData=16'h1234.
  - MEM_memOut unchanged; Stall high 2 cycles.
- Load at addr=16'h0011:
  - No dm_rd; Stall=0; err=1 next cycle, remaining 1 after the load advances.
  - memRead=memWrite=1 at an aligned address behaves the same way.
- Load with dm_done never asserted, TIMEOUT=4:
  - ACCESS lasts 4 cycles, then DONE with MEM_memOut=16'hFFFF and err=1.
  - Stall low in DONE.
- Two back-to-back loads returning 16'h0001 then 16'h0002:
  - Two separate ACCESS phases, each followed by a DONE cycle.
  - No duplicate request while the first load sits in DONE; outputs 1 then 2.
- rst low in the middle of ACCESS:
  - dm_rd=0 and Stall=0 immediately; all outputs at reset values.
  - A stale dm_done after release changes nothing.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-stage access controller for the 16-bit pipeline.
// Turns a load/store in MEM into a level-held request to a multi-cycle
// data memory, stalls the pipeline until it completes, registers load data
// for MEM/WB, and raises a sticky error on misaligned/conflicting/timed-out
// accesses.
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [15:0] addr,
  input  logic [15:0] wrData,
  input  logic [15:0] dm_rdData,
  input  logic        dm_done,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wrData,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic [15:0] MEM_memOut,
  output logic        Stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Last counter value allowed in ACCESS; the access is abandoned there.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic        op_rd_reg;
  logic        op_wr_reg;
  logic [15:0] addr_reg;
  logic [15:0] wdata_reg;
  logic [15:0] memout_reg;
  logic        err_reg;

  logic acc;
  logic bad;

  assign acc = memRead | memWrite;
  assign bad = acc & (addr[0] | (memRead & memWrite));

  // Access FSM: latches the request in IDLE, waits for completion or timeout
  // in ACCESS, and spends one DONE cycle so the held instruction is not reissued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 8'd0;
      op_rd_reg  <= 1'b0;
      op_wr_reg  <= 1'b0;
      addr_reg   <= 16'h0000;
      wdata_reg  <= 16'h0000;
      memout_reg <= 16'h0000;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (acc && !bad) begin
            addr_reg  <= addr;
            wdata_reg <= wrData;
            op_rd_reg <= memRead;
            op_wr_reg <= memWrite;
            cnt_reg   <= 8'd0;
            state_reg <= ACCESS;
          end else if (bad) begin
            err_reg <= 1'b1;
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg + 8'd1;
          if (dm_done) begin
            // Completion takes priority over a simultaneous timeout.
            if (op_rd_reg) begin
              memout_reg <= dm_rdData;
            end
            state_reg <= DONE;
          end else if (cnt_reg == TMO_LAST) begin
            err_reg    <= 1'b1;
            memout_reg <= 16'hFFFF;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Stall holds the pipeline from request acceptance through ACCESS; it is
  // forced low while reset is asserted.
  always_comb begin
    Stall = 1'b0;
    if (rst) begin
      Stall = ((state_reg == IDLE) && acc && !bad) || (state_reg == ACCESS);
    end
  end

  assign dm_rd      = (state_reg == ACCESS) & op_rd_reg;
  assign dm_wr      = (state_reg == ACCESS) & op_wr_reg;
  assign dm_addr    = addr_reg;
  assign dm_wrData  = wdata_reg;
  assign MEM_memOut = memout_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: transaction-level self-checking bench for mem_stage.
// Each instruction is held until Stall is low; the expected request length,
// load result and error flag are computed from the access rules directly.
module tb_mem_stage;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [15:0] addr;
  logic [15:0] wrData;
  logic [15:0] dm_rdData;
  logic        dm_done;
  logic [15:0] dm_addr;
  logic [15:0] dm_wrData;
  logic        dm_rd;
  logic        dm_wr;
  logic [15:0] MEM_memOut;
  logic        Stall;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] exp_mem;
  logic        exp_err;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .wrData(wrData),
    .dm_rdData(dm_rdData), .dm_done(dm_done),
    .dm_addr(dm_addr), .dm_wrData(dm_wrData),
    .dm_rd(dm_rd), .dm_wr(dm_wr),
    .MEM_memOut(MEM_memOut), .Stall(Stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b0;
    memRead = 1'b0; memWrite = 1'b0; addr = 16'h0; wrData = 16'h0;
    dm_rdData = 16'h0; dm_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_mem = 16'h0000;
    exp_err = 1'b0;
  endtask

  // One instruction in MEM. k = ACCESS cycle on which dm_done is pulsed
  // (0 = never; k > TIMEOUT lands after expiry).
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input int k, input logic [15:0] rdata);
    int n_stall = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_cyc = 0;
    int exp_stall, exp_rd, exp_wr, n_acc;
    logic addr_bad = 1'b0;
    logic wd_bad = 1'b0;
    logic ended = 1'b0;
    logic acc, bad, in_time;
    logic [15:0] mem_seen = 16'h0;

    memRead = rd; memWrite = wr; addr = a; wrData = d;
    for (int i = 0; i < 20 && !ended; i++) begin
      dm_done   = (k != 0) && (i == k);
      dm_rdData = (i == k) ? rdata : 16'($urandom);
      @(negedge clk);
      n_cyc++;
      if (Stall) n_stall++;
      if (dm_rd) n_rd++;
      if (dm_wr) n_wr++;
      if ((dm_rd || dm_wr) && dm_addr !== a) addr_bad = 1'b1;
      if (dm_wr && dm_wrData !== d) wd_bad = 1'b1;
      if (!Stall) begin
        ended = 1'b1;
        mem_seen = MEM_memOut;
      end
      @(posedge clk); #1;
    end
    memRead = 1'b0; memWrite = 1'b0; dm_done = 1'b0;

    // Expected behaviour from the access rules
    acc = rd | wr;
    bad = acc & (a[0] | (rd & wr));
    if (!acc || bad) begin
      exp_stall = 0; exp_rd = 0; exp_wr = 0;
      if (bad) exp_err = 1'b1;
    end else begin
      in_time   = (k >= 1) && (k <= TIMEOUT);
      n_acc     = in_time ? k : TIMEOUT;
      exp_stall = 1 + n_acc;
      exp_rd    = rd ? n_acc : 0;
      exp_wr    = wr ? n_acc : 0;
      if (!in_time) begin
        exp_mem = 16'hFFFF;
        exp_err = 1'b1;
      end else if (rd) begin
        exp_mem = rdata;
      end
    end

    $display("txn rd=%0d wr=%0d addr=%h wd=%h k=%0d rdata=%h -> cycles=%0d memOut=%h err=%0d",
             rd, wr, a, d, k, rdata, n_cyc, mem_seen, err);

    n_vec++;
    if (ended !== 1'b1) begin
      n_err++; $display("FAIL txn_complete: Stall never dropped within cycle budget");
    end
    n_vec++;
    if (n_stall !== exp_stall) begin
      n_err++; $display("FAIL stall_cycles: got %0d expected %0d", n_stall, exp_stall);
    end
    n_vec++;
    if (n_rd !== exp_rd) begin
      n_err++; $display("FAIL dm_rd_cycles: got %0d expected %0d", n_rd, exp_rd);
    end
    n_vec++;
    if (n_wr !== exp_wr) begin
      n_err++; $display("FAIL dm_wr_cycles: got %0d expected %0d", n_wr, exp_wr);
    end
    n_vec++;
    if (addr_bad !== 1'b0) begin
      n_err++; $display("FAIL dm_addr: wrong address during request, expected %h", a);
    end
    n_vec++;
    if (wd_bad !== 1'b0) begin
      n_err++; $display("FAIL dm_wrData: wrong store data during request, expected %h", d);
    end
    n_vec++;
    if (mem_seen !== exp_mem) begin
      n_err++; $display("FAIL memOut: got %h expected %h", mem_seen, exp_mem);
    end
    n_vec++;
    if (err !== exp_err) begin
      n_err++; $display("FAIL err: got %0d expected %0d", err, exp_err);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (MEM_memOut !== 16'h0) begin n_err++; $display("FAIL reset_memOut: got %h expected 0000", MEM_memOut); end
    n_vec++;
    if (dm_addr !== 16'h0) begin n_err++; $display("FAIL reset_dm_addr: got %h expected 0000", dm_addr); end
    n_vec++;
    if (dm_wrData !== 16'h0) begin n_err++; $display("FAIL reset_dm_wrData: got %h expected 0000", dm_wrData); end
    n_vec++;
    if ({dm_rd, dm_wr, err, Stall} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got rd/wr/err/stall=%b expected 0000", {dm_rd, dm_wr, err, Stall});
    end
    $display("txn reset done");
  endtask

  task automatic test_load_basic();
    run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2, 16'hBEEF);
  endtask

  task automatic test_store();
    run_txn(1'b0, 1'b1, 16'h0020, 16'h1234, 1, 16'h5555);
  endtask

  task automatic test_misaligned();
    apply_reset();
    run_txn(1'b1, 1'b0, 16'h0011, 16'h0000, 1, 16'h7777);
    apply_reset();
    run_txn(1'b1, 1'b1, 16'h0010, 16'hABCD, 1, 16'h7777);
  endtask

  task automatic test_timeout();
    apply_reset();
    run_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'h0000);
    apply_reset();
    run_txn(1'b1, 1'b0, 16'h0042, 16'h0000, TIMEOUT, 16'h4242);
    apply_reset();
    run_txn(1'b0, 1'b1, 16'h0044, 16'h9999, TIMEOUT + 1, 16'h0000);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    run_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'h0001);
    run_txn(1'b1, 1'b0, 16'h0102, 16'h0000, 1, 16'h0002);
    run_txn(1'b0, 1'b0, 16'h0104, 16'h0000, 0, 16'h0000);
  endtask

  task automatic test_random();
    logic rd, wr;
    logic [15:0] a;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom);
      wr = ($urandom_range(0, 3) == 0) ? rd : ~rd;
      a  = 16'($urandom);
      if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
      run_txn(rd, wr, a, 16'($urandom), int'($urandom_range(0, TIMEOUT + 1)), 16'($urandom));
    end
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    run_txn(1'b1, 1'b0, 16'h0030, 16'h0000, 1, 16'hC0DE);
    memRead = 1'b1; addr = 16'h0032; dm_done = 1'b0;
    @(posedge clk); #1;          // now in ACCESS
    @(posedge clk); #2;          // second ACCESS cycle
    rst = 1'b0;
    #1;
    n_vec++;
    if (dm_rd !== 1'b0) begin n_err++; $display("FAIL rstmid_dm_rd: got %0d expected 0", dm_rd); end
    n_vec++;
    if (Stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stall: got %0d expected 0", Stall); end
    n_vec++;
    if (MEM_memOut !== 16'h0) begin n_err++; $display("FAIL rstmid_memOut: got %h expected 0000", MEM_memOut); end
    n_vec++;
    if (dm_addr !== 16'h0) begin n_err++; $display("FAIL rstmid_dm_addr: got %h expected 0000", dm_addr); end
    memRead = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    dm_done = 1'b1; dm_rdData = 16'hDEAD;
    @(posedge clk); #1;
    dm_done = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({dm_rd, Stall, err} !== 3'b0) begin
      n_err++; $display("FAIL stale_done_flags: got rd/stall/err=%b expected 000", {dm_rd, Stall, err});
    end
    n_vec++;
    if (MEM_memOut !== 16'h0) begin n_err++; $display("FAIL stale_done_memOut: got %h expected 0000", MEM_memOut); end
    @(posedge clk); #1;
    $display("txn reset mid-access done");
    exp_mem = 16'h0000;
    exp_err = 1'b0;
    run_txn(1'b1, 1'b0, 16'h0050, 16'h0000, 3, 16'h5A5A);
  endtask

  initial begin
    rst = 1'b0;
    memRead = 1'b0; memWrite = 1'b0; addr = 16'h0; wrData = 16'h0;
    dm_rdData = 16'h0; dm_done = 1'b0;
    exp_mem = 16'h0; exp_err = 1'b0;
    test_reset();
    test_load_basic();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
